// File: rtl/interp_upsampler_if.sv
// Handshake bundle for interp_upsampler: staged input samples in, valid/ready sample stream out.
// INTERP_MUTE_EN adds the per-burst mute input.
interface interp_upsampler_if #(
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 20,
    parameter int CHANNELS = 2
) ();
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sample;
    logic [CH_W-1:0]          in_ch;
    logic                     mode;
`ifdef INTERP_MUTE_EN
    logic                     mute;
`endif

    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_sample;
    logic [CH_W-1:0]          out_ch;
    logic                     busy;
    logic                     overrun;

    modport slave (
`ifdef INTERP_MUTE_EN
        input  mute,
`endif
        input  in_valid, in_sample, in_ch, mode, out_ready,
        output out_valid, out_sample, out_ch, busy, overrun
    );

    modport master (
`ifdef INTERP_MUTE_EN
        output mute,
`endif
        output in_valid, in_sample, in_ch, mode, out_ready,
        input  out_valid, out_sample, out_ch, busy, overrun
    );
endinterface

// File: rtl/interp_upsampler.sv
// Multi-channel integer-ratio upsampler: one committed frame becomes RATIO output frames, ZOH or linear.
// Optional macro INTERP_MUTE_EN: mute input latched at commit zeroes the whole burst.
module interp_upsampler #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 20,
    parameter int RATIO_LOG2 = 3,
    parameter int CHANNELS   = 2
) (
    input logic               clk,
    input logic               rst,
    interp_upsampler_if.slave bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RATIO  = 1 << RATIO_LOG2;
    localparam int K_W    = RATIO_LOG2 + 1;
    localparam int PROD_W = DATA_W + 2 + RATIO_LOG2;
    localparam int SHIFT  = OUT_W - DATA_W;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [K_W-1:0]  LAST_K  = K_W'(RATIO);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_W-1:0] r_stage [CHANNELS];
    logic signed [DATA_W-1:0] r_prev  [CHANNELS];
    logic signed [DATA_W-1:0] r_curr  [CHANNELS];

    logic [K_W-1:0]  r_k;
    logic [CH_W-1:0] r_ch;
    logic            r_mode;
    logic            r_overrun;
    logic            w_mute;

    logic w_in_ok;
    logic w_commit;
    logic w_last_acc;
    logic w_load;
    logic w_drop;
    logic w_advance;

    logic signed [DATA_W-1:0] w_prev_c;
    logic signed [DATA_W-1:0] w_curr_c;
    logic signed [DATA_W:0]   w_d;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [DATA_W-1:0] w_y_lin;
    logic signed [DATA_W-1:0] w_y;
    logic signed [OUT_W-1:0]  w_y_ext;

    assign w_in_ok    = bus.in_valid && ({1'b0, bus.in_ch} < (CH_W + 1)'(CHANNELS));
    assign w_commit   = bus.in_valid && (bus.in_ch == LAST_CH);
    assign w_last_acc = bus.out_ready && (r_k == LAST_K) && (r_ch == LAST_CH);
    assign w_advance  = (r_state == EMIT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A commit landing on the final acceptance starts the next burst directly, without an IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_commit) begin
                    w_state_nxt = EMIT;
                    w_load      = 1'b1;
                end
            end
            EMIT: begin
                if (w_last_acc) begin
                    w_state_nxt = w_commit ? EMIT : IDLE;
                    w_load      = w_commit;
                end else begin
                    w_drop = w_commit;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef INTERP_MUTE_EN
    logic r_mute;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mute <= 1'b0;
        end else if (w_load) begin
            r_mute <= bus.mute;
        end
    end

    assign w_mute = r_mute;
`else
    assign w_mute = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_stage[c] <= '0;
                r_prev[c]  <= '0;
                r_curr[c]  <= '0;
            end
            r_k       <= '0;
            r_ch      <= '0;
            r_mode    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_in_ok) begin
                r_stage[bus.in_ch] <= bus.in_sample;
            end
            if (w_load) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    r_prev[c] <= r_curr[c];
                    r_curr[c] <= (c == CHANNELS - 1) ? bus.in_sample : r_stage[c];
                end
                r_mode <= bus.mode;
                r_k    <= K_W'(1);
                r_ch   <= '0;
            end else if (w_advance) begin
                if (r_ch == LAST_CH) begin
                    r_ch <= '0;
                    r_k  <= r_k + 1'b1;
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
        end
    end

    // Product extended to full width so the floor shift and the k=RATIO endpoint are exact.
    always_comb begin
        w_prev_c = r_prev[r_ch];
        w_curr_c = r_curr[r_ch];
        w_d      = {w_curr_c[DATA_W-1], w_curr_c} - {w_prev_c[DATA_W-1], w_prev_c};
        w_prod   = {{(PROD_W - DATA_W - 1){w_d[DATA_W]}}, w_d} * {{(PROD_W - K_W){1'b0}}, r_k};
        w_y_lin  = w_prev_c + DATA_W'(w_prod >>> RATIO_LOG2);
        if (w_mute) begin
            w_y = '0;
        end else if (r_mode) begin
            w_y = w_y_lin;
        end else begin
            w_y = w_curr_c;
        end
        w_y_ext = OUT_W'(w_y);
    end

    assign bus.out_valid  = (r_state == EMIT);
    assign bus.busy       = (r_state == EMIT);
    assign bus.out_sample = (r_state == EMIT) ? (w_y_ext <<< SHIFT) : '0;
    assign bus.out_ch     = (r_state == EMIT) ? r_ch : '0;
    assign bus.overrun    = r_overrun;
endmodule
